// File: rtl/prediction_gshare.sv
// Branch-direction predictor: table of saturating counters indexed by PC (optionally
// XORed with global history), with a non-speculative update port and saturating statistics.
`timescale 1ns/1ps
module prediction_gshare #(
  parameter int IDX_W = 6,
  parameter int GHR_W = 6,
  parameter int CNT_W = 2,
  parameter int PC_W  = 16,
  parameter int MODE  = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             pred_valid_i,
  output logic             pred_ready_o,
  input  logic [PC_W-1:0]  pred_pc_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  input  logic             upd_mispred_i,
  input  logic [1:0]       stat_sel_i,
  input  logic             stat_clr_i,
  output logic [31:0]      stat_o
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_MAX >> 1;

  logic [0:0]       state_reg, state_next;
  logic [IDX_W-1:0] sweep_reg, sweep_next;
  logic [GHR_W-1:0] ghr_reg, ghr_next, ghr_shift;
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] pred_idx;
  logic             run;
  logic             accept;
  logic             upd_apply;

  logic [CNT_W-1:0] table_mem [DEPTH];
  logic [CNT_W-1:0] rd_cnt_reg;
  logic [CNT_W-1:0] upd_cur;
  logic [CNT_W-1:0] upd_new;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [CNT_W-1:0] wr_data;

  logic             pred_valid_reg;
  logic [IDX_W-1:0] pred_idx_reg;

  logic [31:0]      stat_reg [3];
  logic [2:0]       stat_inc;
  logic [31:0]      status_word;
  logic             unused_bits;

  assign run       = (state_reg == ST_RUN);
  assign accept    = pred_valid_i && run;
  assign upd_apply = upd_valid_i && run;

  // History zero-extended to the index width.
  generate
    for (genvar gi = 0; gi < IDX_W; gi++) begin : g_ghr_ext
      if (gi < GHR_W) begin : g_bit
        assign ghr_ext[gi] = ghr_reg[gi];
      end else begin : g_zero
        assign ghr_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign pc_idx   = pred_pc_i[IDX_W+1:2];
  assign pred_idx = (MODE != 0) ? (pc_idx ^ ghr_ext) : pc_idx;

  generate
    if (GHR_W == 1) begin : g_ghr1
      assign ghr_shift = upd_taken_i;
    end else begin : g_ghrn
      assign ghr_shift = {ghr_reg[GHR_W-2:0], upd_taken_i};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    sweep_next = sweep_reg;
    ghr_next   = ghr_reg;
    if (state_reg == ST_INIT) begin
      sweep_next = sweep_reg + 1'b1;
      if (&sweep_reg) begin
        state_next = ST_RUN;
      end
    end
    if (upd_apply) begin
      ghr_next = ghr_shift;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg      <= ST_INIT;
      sweep_reg      <= '0;
      ghr_reg        <= '0;
      pred_valid_reg <= 1'b0;
      pred_idx_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      sweep_reg      <= sweep_next;
      ghr_reg        <= ghr_next;
      pred_valid_reg <= accept;
      if (accept) begin
        pred_idx_reg <= pred_idx;
      end
    end
  end

  // Saturating read-modify-write for the resolve port.
  always_comb begin
    upd_cur = table_mem[upd_idx_i];
    upd_new = upd_cur;
    if (upd_taken_i) begin
      if (upd_cur != CNT_MAX) upd_new = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_new = upd_cur - 1'b1;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = upd_idx_i;
    wr_data = upd_new;
    if (state_reg == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = sweep_reg;
      wr_data = CNT_WNT;
    end else if (upd_apply) begin
      wr_en = 1'b1;
    end
  end

  // Registered read sees the pre-write contents, giving read-before-write on index collisions.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      table_mem[wr_addr] <= wr_data;
    end
    if (accept) begin
      rd_cnt_reg <= table_mem[pred_idx];
    end
  end

  assign pred_ready_o = run;
  assign pred_valid_o = pred_valid_reg;
  assign pred_taken_o = pred_valid_reg & rd_cnt_reg[CNT_W-1];
  assign pred_idx_o   = pred_valid_reg ? pred_idx_reg : '0;

  assign stat_inc = {upd_apply && upd_mispred_i, upd_apply, accept};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < 3; i++) stat_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stat_clr_i) begin
          stat_reg[i] <= '0;
        end else if (stat_inc[i] && (stat_reg[i] != 32'hFFFF_FFFF)) begin
          stat_reg[i] <= stat_reg[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    status_word     = 32'(ghr_reg);
    status_word[31] = run;
    case (stat_sel_i)
      2'd0:    stat_o = stat_reg[0];
      2'd1:    stat_o = stat_reg[1];
      2'd2:    stat_o = stat_reg[2];
      default: stat_o = status_word;
    endcase
  end

  assign unused_bits = ^{pred_pc_i, ghr_ext, rd_cnt_reg};

endmodule
